// File: rtl/jtopl_pg_pkg.sv
// Shared constants, index types and the frequency-multiplier table for the
// OPL phase generator.
package jtopl_pg_pkg;

  localparam int unsigned NSLOT   = 18;
  localparam int unsigned NCH     = 9;
  localparam int unsigned PHASE_W = 20;
  localparam int unsigned PHINC_W = 17;

  typedef logic [4:0] slot_t;
  typedef logic [3:0] ch_t;

  // MULT register to integer factor; code 0 is a half step handled in the datapath.
  function automatic logic [3:0] mul_factor(input logic [3:0] mul);
    logic [3:0] f;
    case (mul)
      4'd0:         f = 4'd1;
      4'd11:        f = 4'd10;
      4'd13:        f = 4'd12;
      4'd14, 4'd15: f = 4'd15;
      default:      f = mul;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/jtopl_pg_comb.sv
// Per-slot phase arithmetic: vibrato/block scaling feeds stage A, the
// multiplier and accumulator feed stage B.
module jtopl_pg_comb
  import jtopl_pg_pkg::*;
(
  input  logic [9:0]         fnum,
  input  logic [2:0]         block,
  input  logic               viben,
  input  logic [4:0]         lfo_mod,
  input  logic               vib_dep,
  output logic [3:0]         keycode,
  output logic [PHINC_W-1:0] phinc_out,
  input  logic [3:0]         mul,
  input  logic [PHASE_W-1:0] phase_in,
  input  logic [PHINC_W-1:0] phinc_in,
  input  logic               pg_rst,
  output logic [PHASE_W-1:0] phase_out,
  output logic [9:0]         phase_op
);

  logic [6:0]         vib_prod;
  logic [6:0]         vib_mag;
  logic [10:0]        fnum_mod;
  logic [PHASE_W-1:0] scaled;

  assign keycode = {block, fnum[9]};

  always_comb begin
    // Vibrato depth tracks the top fnum bits; lfo_mod[4] selects the sign.
    vib_prod = 7'(lfo_mod[3:0]) * 7'(fnum[9:7]);
    vib_mag  = vib_dep ? (vib_prod >> 3) : (vib_prod >> 4);
    fnum_mod = {1'b0, fnum};
    if (viben) begin
      fnum_mod = lfo_mod[4] ? fnum_mod - {4'b0, vib_mag} : fnum_mod + {4'b0, vib_mag};
    end
    phinc_out = PHINC_W'(({7'b0, fnum_mod} << block) >> 1);
  end

  always_comb begin
    if (mul == 4'd0) begin
      scaled = {3'b0, phinc_in} >> 1;
    end else begin
      scaled = {3'b0, phinc_in} * {16'b0, mul_factor(mul)};
    end
    phase_out = pg_rst ? '0 : phase_in + scaled;
    phase_op  = phase_out[PHASE_W-1:PHASE_W-10];
  end

endmodule

// File: rtl/jtopl_pg_seq.sv
// Time-multiplexed phase generator for 18 slots with key-on phase reset.
// Define JTOPL_PG_DBG_EN to build the dbg_slot -> dbg_phase read mux.
module jtopl_pg_seq
  import jtopl_pg_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cenop,
  input  logic               wr_ch_en,
  input  logic [3:0]         wr_ch,
  input  logic [9:0]         wr_fnum,
  input  logic [2:0]         wr_block,
  input  logic               wr_op_en,
  input  logic [4:0]         wr_slot,
  input  logic [3:0]         wr_mul,
  input  logic               wr_viben,
  input  logic [4:0]         lfo_mod,
  input  logic               vib_dep,
  input  logic               kon_req,
  input  logic [3:0]         kon_ch,
  output logic               kon_ack,
  output logic [9:0]         phase_op,
  output logic [4:0]         op_slot,
  output logic [3:0]         keycode,
  output logic               zero,
  input  logic [4:0]         dbg_slot,
  output logic [PHASE_W-1:0] dbg_phase
);

  slot_t              cnt_q;
  ch_t                ch_cur;
  logic [9:0]         fnum_q  [NCH];
  logic [2:0]         block_q [NCH];
  logic [3:0]         mul_q   [NSLOT];
  logic [NSLOT-1:0]   viben_q;
  logic [PHASE_W-1:0] phase_q [NSLOT];
  logic [NSLOT-1:0]   pend_q, pend_d, pend_set, pend_clr;

  logic               a_valid_q, a_rst_q;
  logic [PHINC_W-1:0] a_phinc_q;
  logic [3:0]         a_mul_q, a_kc_q;
  slot_t              a_slot_q;

  logic [3:0]         kc_a;
  logic [PHINC_W-1:0] phinc_a;
  logic [PHASE_W-1:0] phase_b;
  logic [9:0]         op_b;
  logic               kon_acc, kon_hit;

  assign ch_cur = cnt_q[4:1];
  assign zero   = (cnt_q == '0);

  jtopl_pg_comb u_comb (
    .fnum      (fnum_q[ch_cur]),
    .block     (block_q[ch_cur]),
    .viben     (viben_q[cnt_q]),
    .lfo_mod   (lfo_mod),
    .vib_dep   (vib_dep),
    .keycode   (kc_a),
    .phinc_out (phinc_a),
    .mul       (a_mul_q),
    .phase_in  (phase_q[a_slot_q]),
    .phinc_in  (a_phinc_q),
    .pg_rst    (a_rst_q),
    .phase_out (phase_b),
    .phase_op  (op_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        fnum_q[i]  <= '0;
        block_q[i] <= '0;
      end
      for (int i = 0; i < NSLOT; i++) mul_q[i] <= '0;
      viben_q <= '0;
    end else begin
      if (wr_ch_en && wr_ch < ch_t'(NCH)) begin
        fnum_q[wr_ch]  <= wr_fnum;
        block_q[wr_ch] <= wr_block;
      end
      if (wr_op_en && wr_slot < slot_t'(NSLOT)) begin
        mul_q[wr_slot]   <= wr_mul;
        viben_q[wr_slot] <= wr_viben;
      end
    end
  end

  // Stage A captures slot cnt_q; stage B retires the slot captured on the previous tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      a_valid_q <= 1'b0;
      a_rst_q   <= 1'b0;
      a_phinc_q <= '0;
      a_mul_q   <= '0;
      a_kc_q    <= '0;
      a_slot_q  <= '0;
      phase_op  <= '0;
      op_slot   <= '0;
      keycode   <= '0;
      for (int i = 0; i < NSLOT; i++) phase_q[i] <= '0;
    end else if (cenop) begin
      cnt_q     <= (cnt_q == slot_t'(NSLOT - 1)) ? '0 : cnt_q + 5'd1;
      a_valid_q <= 1'b1;
      a_rst_q   <= pend_q[cnt_q];
      a_phinc_q <= phinc_a;
      a_mul_q   <= mul_q[cnt_q];
      a_kc_q    <= kc_a;
      a_slot_q  <= cnt_q;
      if (a_valid_q) begin
        phase_q[a_slot_q] <= phase_b;
        phase_op          <= op_b;
        keycode           <= a_kc_q;
        op_slot           <= a_slot_q;
      end
    end
  end

  assign kon_acc = kon_req & ~kon_ack;
  assign kon_hit = kon_acc & (kon_ch < ch_t'(NCH));

  // A set landing on the same edge as the stage-B clear wins.
  always_comb begin
    pend_clr = '0;
    pend_set = '0;
    if (cenop && a_valid_q) pend_clr[a_slot_q] = 1'b1;
    if (kon_hit) begin
      pend_set[{kon_ch, 1'b0}] = 1'b1;
      pend_set[{kon_ch, 1'b1}] = 1'b1;
    end
    pend_d = (pend_q & ~pend_clr) | pend_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= '0;
      kon_ack <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      kon_ack <= kon_acc;
    end
  end

`ifdef JTOPL_PG_DBG_EN
  assign dbg_phase = (dbg_slot < slot_t'(NSLOT)) ? phase_q[dbg_slot] : '0;
`else
  logic unused_dbg_slot;
  assign unused_dbg_slot = ^dbg_slot;
  assign dbg_phase       = '0;
`endif

endmodule

// File: tb/tb_jtopl_pg_seq.sv
// Self-checking bench for jtopl_pg_seq: directed scenarios plus random traffic
// against a slot-level reference model.
module tb_jtopl_pg_seq;
  import jtopl_pg_pkg::*;

  logic        clk = 1'b0;
  logic        rst, cenop, wr_ch_en, wr_op_en, wr_viben, vib_dep, kon_req;
  logic [3:0]  wr_ch, wr_mul, kon_ch, keycode;
  logic [9:0]  wr_fnum, phase_op;
  logic [2:0]  wr_block;
  logic [4:0]  wr_slot, lfo_mod, op_slot, dbg_slot;
  logic        kon_ack, zero;
  logic [19:0] dbg_phase;

  int checks = 0;
  int errors = 0;

  jtopl_pg_seq dut (
    .clk(clk), .rst(rst), .cenop(cenop),
    .wr_ch_en(wr_ch_en), .wr_ch(wr_ch), .wr_fnum(wr_fnum), .wr_block(wr_block),
    .wr_op_en(wr_op_en), .wr_slot(wr_slot), .wr_mul(wr_mul), .wr_viben(wr_viben),
    .lfo_mod(lfo_mod), .vib_dep(vib_dep), .kon_req(kon_req), .kon_ch(kon_ch),
    .kon_ack(kon_ack), .phase_op(phase_op), .op_slot(op_slot), .keycode(keycode),
    .zero(zero), .dbg_slot(dbg_slot), .dbg_phase(dbg_phase)
  );

  always #5 clk = ~clk;

  // Reference model state: tables, one in-flight slot record, visible outputs.
  int unsigned m_fnum [9], m_block [9], m_mul [18], m_viben [18], m_phase [18];
  bit          m_pend [18];
  int unsigned m_cnt, m_op, m_kc, m_slot;
  bit          m_ack;
  bit          a_valid, a_rst;
  int unsigned a_slot, a_phinc, a_mul, a_kc;
  int unsigned fac [16] = '{1, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 10, 12, 12, 15, 15};

  function automatic int unsigned f_phinc(int unsigned fnum, int unsigned block,
                                          int unsigned viben, int unsigned lfo,
                                          int unsigned dep);
    int unsigned mag = ((lfo % 16) * (fnum / 128)) / (dep != 0 ? 8 : 16);
    int unsigned f   = fnum;
    if (viben != 0) f = (lfo >= 16) ? fnum - mag : fnum + mag;
    return (f * (1 << block)) / 2;
  endfunction

  function automatic int unsigned f_step(int unsigned phinc, int unsigned mul);
    return (mul == 0) ? phinc / 2 : phinc * fac[mul];
  endfunction

  task automatic model_edge();
    bit acc;
    int unsigned ch, p, k, n_slot, n_phinc, n_mul, n_kc;
    bit n_rst;
    if (rst) begin
      for (int i = 0; i < 9; i++) begin m_fnum[i] = 0; m_block[i] = 0; end
      for (int i = 0; i < 18; i++) begin
        m_mul[i] = 0; m_viben[i] = 0; m_phase[i] = 0; m_pend[i] = 0;
      end
      m_cnt = 0; m_op = 0; m_kc = 0; m_slot = 0; m_ack = 0;
      a_valid = 0; a_rst = 0; a_slot = 0; a_phinc = 0; a_mul = 0; a_kc = 0;
    end else begin
      acc = kon_req && !m_ack;
      if (cenop) begin
        ch      = m_cnt / 2;
        n_slot  = m_cnt;
        n_phinc = f_phinc(m_fnum[ch], m_block[ch], m_viben[m_cnt], 32'(lfo_mod), 32'(vib_dep));
        n_mul   = m_mul[m_cnt];
        n_rst   = m_pend[m_cnt];
        n_kc    = m_block[ch] * 2 + m_fnum[ch] / 512;
        if (a_valid) begin
          p = a_rst ? 0 : (m_phase[a_slot] + f_step(a_phinc, a_mul)) % (1 << 20);
          m_phase[a_slot] = p;
          m_op   = p >> 10;
          m_kc   = a_kc;
          m_slot = a_slot;
          m_pend[a_slot] = 0;
        end
        a_valid = 1; a_slot = n_slot; a_phinc = n_phinc; a_mul = n_mul;
        a_rst = n_rst; a_kc = n_kc;
        m_cnt = (m_cnt + 1) % 18;
      end
      k = 32'(kon_ch);
      if (acc && k < 9) begin m_pend[2 * k] = 1; m_pend[2 * k + 1] = 1; end
      m_ack = acc;
      k = 32'(wr_ch);
      if (wr_ch_en && k < 9) begin m_fnum[k] = 32'(wr_fnum); m_block[k] = 32'(wr_block); end
      k = 32'(wr_slot);
      if (wr_op_en && k < 18) begin m_mul[k] = 32'(wr_mul); m_viben[k] = 32'(wr_viben); end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    int unsigned dexp;
    @(posedge clk);
    model_edge();
    #1;
    chk("kon_ack", 32'(kon_ack), 32'(m_ack));
    chk("zero", 32'(zero), 32'(m_cnt == 0));
    chk("op_slot", 32'(op_slot), m_slot);
    chk("phase_op", 32'(phase_op), m_op);
    chk("keycode", 32'(keycode), m_kc);
`ifdef JTOPL_PG_DBG_EN
    dexp = (dbg_slot < 5'd18) ? m_phase[dbg_slot] : 0;
`else
    dexp = 0;
`endif
    chk("dbg_phase", 32'(dbg_phase), dexp);
  endtask

  task automatic idle_writes();
    wr_ch_en = 0; wr_op_en = 0; wr_ch = 0; wr_fnum = 0; wr_block = 0;
    wr_slot = 0; wr_mul = 0; wr_viben = 0;
  endtask

  task automatic wait_op(input int s);
    int n = 0;
    while (32'(op_slot) != s && n < 40) begin step(); n++; end
    chk("wait_op_slot", 32'(op_slot), s);
  endtask

  task automatic wait_zero();
    int n = 0;
    while (!zero && n < 40) begin step(); n++; end
    chk("wait_zero", 32'(zero), 1);
  endtask

  task automatic set_loud(input int ch);
    wr_ch_en = 1; wr_ch = 4'(ch); wr_fnum = 10'h3ff; wr_block = 3'd7;
    step();
    idle_writes();
    for (int s = 2 * ch; s < 2 * ch + 2; s++) begin
      wr_op_en = 1; wr_slot = 5'(s); wr_mul = 4'd15; wr_viben = 0;
      step();
    end
    idle_writes();
  endtask

  initial begin
    int prev, wraps, n;
    rst = 1; cenop = 0; kon_req = 0; kon_ch = 0; lfo_mod = 0; vib_dep = 0; dbg_slot = 0;
    idle_writes();
    repeat (3) step();
    chk("rst_zero", 32'(zero), 1);
    chk("rst_op_slot", 32'(op_slot), 0);
    chk("rst_phase_op", 32'(phase_op), 0);
    chk("rst_keycode", 32'(keycode), 0);
    chk("rst_kon_ack", 32'(kon_ack), 0);

    // Counter walk: zero at cycles 0/18/36, op_slot trails by two ticks.
    rst = 0; cenop = 1;
    for (int c = 0; c < 40; c++) begin
      chk("cnt_zero", 32'(zero), 32'(c % 18 == 0));
      chk("cnt_op_slot", 32'(op_slot), (c < 2) ? 0 : (c - 2) % 18);
      step();
    end

    // Accumulation on slot 0: +0x1000 per frame, phase_op +4, wraps at 2^20.
    wr_ch_en = 1; wr_ch = 0; wr_fnum = 10'h200; wr_block = 3'd4;
    wr_op_en = 1; wr_slot = 0; wr_mul = 4'd1; wr_viben = 0;
    step();
    idle_writes();
    prev = -1; wraps = 0;
    for (int c = 0; c < 262 * 18; c++) begin
      step();
      if (op_slot == 5'd0) begin
        if (prev >= 0) begin
          chk("acc_delta", 32'((int'(phase_op) - prev) & 1023), 4);
          if (int'(phase_op) < prev) wraps++;
        end
        prev = int'(phase_op);
      end
    end
    chk("acc_wrap", wraps, 1);

    // Random traffic with stalls, vibrato, writes and key-on requests.
    for (int c = 0; c < 2500; c++) begin
      cenop    = ($urandom_range(3) != 0);
      wr_ch_en = ($urandom_range(7) == 0);
      wr_ch    = 4'($urandom_range(10));
      wr_fnum  = 10'($urandom);
      wr_block = 3'($urandom);
      wr_op_en = ($urandom_range(7) == 0);
      wr_slot  = 5'($urandom_range(20));
      wr_mul   = 4'($urandom);
      wr_viben = 1'($urandom);
      lfo_mod  = 5'($urandom);
      vib_dep  = 1'($urandom);
      dbg_slot = 5'($urandom);
      if (kon_req && m_ack) kon_req = 0;
      else if (!kon_req && $urandom_range(15) == 0) begin
        kon_req = 1; kon_ch = 4'($urandom_range(12));
      end
      step();
    end
    idle_writes();
    cenop = 1; lfo_mod = 0; vib_dep = 0;
    n = 0;
    while (kon_req && !m_ack && n < 4) begin step(); n++; end
    kon_req = 0;
    step();

    // Key-on ch3: slots 6 and 7 restart from 0, then count again.
    set_loud(3);
    set_loud(2);
    repeat (36) step();
    wait_zero();
    kon_req = 1; kon_ch = 4'd3;
    step();
    chk("kon3_ack", 32'(kon_ack), 1);
    kon_req = 0;
    wait_op(6);
    chk("kon3_s6_reset", 32'(phase_op), 0);
    step();
    chk("kon3_s7_slot", 32'(op_slot), 7);
    chk("kon3_s7_reset", 32'(phase_op), 0);
    step();
    wait_op(6);
    chk("kon3_s6_resume", 32'(phase_op), 959);

    // Collision: ch2 key-on lands on the edge where slot 4 retires its reset.
    wait_zero();
    kon_req = 1; kon_ch = 4'd2;
    step();
    chk("col_ack1", 32'(kon_ack), 1);
    kon_req = 0;
    repeat (4) step();
    kon_req = 1; kon_ch = 4'd2;
    step();
    chk("col_slot", 32'(op_slot), 4);
    chk("col_first", 32'(phase_op), 0);
    chk("col_ack2", 32'(kon_ack), 1);
    kon_req = 0;
    step();
    wait_op(4);
    chk("col_again", 32'(phase_op), 0);
    step();
    wait_op(4);
    chk("col_resume", 32'(phase_op), 959);

    // Out-of-range key-on and table writes: acked, no table effect.
    kon_req = 1; kon_ch = 4'd12;
    wr_op_en = 1; wr_slot = 5'd20; wr_mul = 4'd3; wr_viben = 1;
    wr_ch_en = 1; wr_ch = 4'd12; wr_fnum = 10'h155; wr_block = 3'd2;
    step();
    chk("rng_ack", 32'(kon_ack), 1);
    kon_req = 0;
    idle_writes();
    repeat (40) step();

    // Reset while a request is outstanding: no ack until rst falls.
    kon_req = 1; kon_ch = 4'd1; rst = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rstreq_noack", 32'(kon_ack), 0);
    end
    rst = 0;
    step();
    chk("rstreq_ack", 32'(kon_ack), 1);
    kon_req = 0;
    for (int c = 0; c < 36; c++) begin
      step();
      chk("rstreq_phase0", 32'(phase_op), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
